data_store_buffer: RTL and testbench
====================================

Name: data_store_buffer

Overview:
- Sits directly upstream of the data cache, between the CPU memory stage and the cache's s_* slave port.
- Posts CPU stores into a DEPTH-entry FIFO so the pipeline does not wait for write completion.
- Lets loads bypass older stores to different words; stalls any load that hits a buffered store's word.
- Serialises all cache traffic: at most one read or one write is outstanding, never both.

Parameters:
DEPTH, 4, store FIFO entries; must be a power of 2.
PTR_W, 2, log2(DEPTH); width of the head/tail pointers.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cpu_req_valid  in  1  CPU request present
cpu_req_wr  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_wstrb  in  4  store byte enables
cpu_req_ready  out  1  request accepted this cycle
cpu_rdata  out  32  load data
cpu_rvalid  out  1  one-cycle pulse, load data valid
buf_empty  out  1  no stores pending or in flight
s_addr  out  32  cache address
s_rready  out  1  cache read request
s_rdata  in  32  cache read data
s_rvalid  in  1  cache read done, one-cycle pulse
s_wdata  out  32  cache write data
s_wvalid  out  4  cache write byte strobes; nonzero = write request
s_wready  in  1  cache write done, one-cycle pulse

Behaviour:
- Reset (synchronous, active-high): head=tail=count=0, load_pend=0, state=IDLE, cpu_rvalid=0, cpu_rdata=0, s_rready=0, s_wvalid=0, s_addr=0, s_wdata=0, buf_empty=1.
- Reset mid-transaction: buffered stores are discarded; s_* requests are low from the cycle after the reset edge.
- Entry format: {addr[31:2], wdata, wstrb}.
- Store accept: cpu_req_ready=1 when count<DEPTH, evaluated on registered count.
  - A pop in the same cycle does not free a slot early.
  - On accept, write the entry at tail, tail<=tail+1 (wraps mod DEPTH), count+1.
  - A store with wstrb=4'b0000 is accepted and dropped (no enqueue), because the cache treats 0 as "no request".
  - Stores produce no cpu_rvalid.
- Load accept: cpu_req_ready = !load_pend && !conflict.
  - conflict = any valid entry, including the head currently in WR_WAIT, with addr[31:2]==cpu_addr[31:2].
  - On accept, latch load_addr and set load_pend.
- cpu_req_ready is combinational from the current request type and cpu_addr.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE: if load_pend, go to RD_WAIT (reads have priority). Else if count>0, go to WR_WAIT with the head entry. Else stay in IDLE.
  - RD_WAIT: s_rready=1, s_addr=load_addr, s_wvalid=0. When s_rvalid=1, set cpu_rdata<=s_rdata, cpu_rvalid<=1 for the next cycle, clear load_pend, and go to IDLE.
  - WR_WAIT: s_wvalid=head.wstrb, s_wdata=head.wdata, s_addr={head.addr,2'b00}, s_rready=0. When s_wready=1, pop: head+1 (wraps), count-1, go to IDLE.
- s_* outputs are decoded from the registered state. They drop in the cycle after the done pulse.
- There is a mandatory one-cycle IDLE bubble between cache transactions, so the cache never sees a stale request.
- Read latency: a load accepted in cycle N has s_rready first high in cycle N+2 when the FSM is idle. cpu_rvalid rises 1 cycle after s_rvalid.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- A load is held behind at most the currently in-flight write.
- cpu_rdata holds its value until the next load completes.
- buf_empty = (count==0) && (state!=WR_WAIT).

Test Plan:
- Reset, then store 0x1000/0xDEADBEEF/4'hF → cpu_req_ready=1. Cycle 2: s_wvalid=4'hF, s_addr=0x1000, s_wdata=0xDEADBEEF. s_wready pulse → buf_empty=1 one cycle later.
- Five stores back-to-back with s_wready held low → first four accepted, fifth sees cpu_req_ready=0. After one s_wready pulse the fifth is accepted, and tail wraps to 0.
- Store to 0x2004, then load from 0x2006 → load stalled (cpu_req_ready=0) until the 0x2004 write completes. Read then issues with s_addr=0x2006.
- Stores to 0x3000 and 0x3004 pending, then load from 0x4000 → read issued before the remaining store. s_rdata=0x12345678 → cpu_rdata=0x12345678 with a one-cycle cpu_rvalid. s_rready and s_wvalid are never high together.
- Store with wstrb=0 → accepted, count stays 0, no s_wvalid.
- Assert rst during WR_WAIT with 3 entries → next cycle count=0, s_wvalid=0, buf_empty=1.

Source files
------------

// File: rtl/data_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : data_store_buffer
// Brief    : Posted-store FIFO between the CPU memory stage and the data
//            cache. Loads bypass older stores to other words, and cache
//            traffic is serialised to one outstanding transaction.
// Revision : 1.0 - initial release
// ============================================================================
module data_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_valid,
    input  logic        cpu_req_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_req_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        buf_empty,
    output logic [31:0] s_addr,
    output logic        s_rready,
    input  logic [31:0] s_rdata,
    input  logic        s_rvalid,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wvalid,
    input  logic        s_wready
);

    localparam int               c_cnt_w   = PTR_W + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_rd_wait = 2'd1;
    localparam logic [1:0] c_wr_wait = 2'd2;

    logic [29:0]        r_addr_mem [DEPTH];
    logic [31:0]        r_data_mem [DEPTH];
    logic [3:0]         r_strb_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_load_pend;
    logic [31:0]        r_load_addr;
    logic [1:0]         r_state;
    logic               r_cpu_rvalid;
    logic [31:0]        r_cpu_rdata;

    logic [DEPTH-1:0]   w_hit;
    logic               w_conflict;
    logic               w_push;
    logic               w_pop;
    logic               w_load_acc;

    // An entry is live when its distance from head is below count; the
    // in-flight head stays live until its write completes.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        logic [PTR_W-1:0] w_offs;
        assign w_offs   = PTR_W'(i) - r_head;
        assign w_hit[i] = ({1'b0, w_offs} < r_count) &&
                          (r_addr_mem[i] == cpu_addr[31:2]);
    end

    assign w_conflict    = |w_hit;
    assign cpu_req_ready = cpu_req_wr ? (r_count < c_depth)
                                      : (!r_load_pend && !w_conflict);
    assign w_push        = cpu_req_valid && cpu_req_wr && cpu_req_ready &&
                           (cpu_wstrb != 4'b0000);
    assign w_load_acc    = cpu_req_valid && !cpu_req_wr && cpu_req_ready;
    assign w_pop         = (r_state == c_wr_wait) && s_wready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_tail] <= cpu_addr[31:2];
            r_data_mem[r_tail] <= cpu_wdata;
            r_strb_mem[r_tail] <= cpu_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_load_pend  <= 1'b0;
            r_load_addr  <= '0;
            r_state      <= c_idle;
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= 1'b0;
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_load_acc) begin
                r_load_pend <= 1'b1;
                r_load_addr <= cpu_addr;
            end
            case (r_state)
                c_idle: begin
                    if (r_load_pend)        r_state <= c_rd_wait;
                    else if (r_count != '0) r_state <= c_wr_wait;
                end
                c_rd_wait: begin
                    if (s_rvalid) begin
                        r_cpu_rdata  <= s_rdata;
                        r_cpu_rvalid <= 1'b1;
                        r_load_pend  <= 1'b0;
                        r_state      <= c_idle;
                    end
                end
                c_wr_wait: begin
                    if (s_wready) r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Cache requests are decoded from state alone; IDLE drives nothing, which
    // gives the bubble cycle between transactions.
    always_comb begin
        s_addr   = '0;
        s_wdata  = '0;
        s_wvalid = '0;
        s_rready = 1'b0;
        case (r_state)
            c_rd_wait: begin
                s_rready = 1'b1;
                s_addr   = r_load_addr;
            end
            c_wr_wait: begin
                s_wvalid = r_strb_mem[r_head];
                s_wdata  = r_data_mem[r_head];
                s_addr   = {r_addr_mem[r_head], 2'b00};
            end
            default: ;
        endcase
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign buf_empty  = (r_count == '0) && (r_state != c_wr_wait);

endmodule
`default_nettype wire

// File: tb/tb_data_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_store_buffer
// Brief    : Directed and randomized bench for data_store_buffer, checked
//            every cycle against a queue-based model of the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_req_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        buf_empty;
    logic [31:0] s_addr;
    logic        s_rready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic [31:0] s_wdata;
    logic [3:0]  s_wvalid;
    logic        s_wready;

    always #5 clk = ~clk;

    data_store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_wr(cpu_req_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_req_ready(cpu_req_ready), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .buf_empty(buf_empty),
        .s_addr(s_addr), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rvalid(s_rvalid), .s_wdata(s_wdata), .s_wvalid(s_wvalid),
        .s_wready(s_wready)
    );

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    // Model: pending stores in order (head in flight included), load state.
    ent_t        q[$];
    bit          m_lpend;
    logic [31:0] m_laddr;
    logic [31:0] m_rdata;
    bit          m_rv;
    bit          p_active, p_done, p_read, p_lpend;
    int          p_qsize;

    int n_checks = 0;
    int n_fail   = 0;

    logic        c_ready, c_srready, c_rvalid, c_empty;
    logic [3:0]  c_swvalid;
    logic [31:0] c_saddr, c_swdata, c_rdata;
    int          c_qsize;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit rresp, input bit wresp, input logic [31:0] rd);
        bit conflict, exp_ready, active;
        @(negedge clk);
        rst = r; cpu_req_valid = v; cpu_req_wr = wr;
        cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
        s_rvalid = 1'b0; s_wready = 1'b0; s_rdata = rd;
        #1;
        s_rvalid = rresp && s_rready;
        s_wready = wresp && (s_wvalid != 4'h0);
        #1;
        c_ready = cpu_req_ready; c_srready = s_rready; c_rvalid = cpu_rvalid;
        c_empty = buf_empty; c_swvalid = s_wvalid; c_saddr = s_addr;
        c_swdata = s_wdata; c_rdata = cpu_rdata; c_qsize = q.size();

        conflict = 1'b0;
        foreach (q[i]) if (q[i].a == a[31:2]) conflict = 1'b1;
        exp_ready = wr ? (q.size() < DEPTH) : (!m_lpend && !conflict);
        chk("req_ready", c_ready, exp_ready);
        chk("buf_empty", c_empty, q.size() == 0);
        chk("cpu_rvalid", c_rvalid, m_rv);
        chk("cpu_rdata", c_rdata, m_rdata);
        active = c_srready || (c_swvalid != 4'h0);
        chk("rd_wr_overlap", c_srready && (c_swvalid != 4'h0), 0);
        if (c_srready) begin
            chk("rd_addr", c_saddr, m_laddr);
            chk("rd_without_load", m_lpend, 1);
        end
        if (c_swvalid != 4'h0) begin
            chk("wr_with_empty_buf", q.size() != 0, 1);
            if (q.size() != 0) begin
                chk("wr_strb", c_swvalid, q[0].s);
                chk("wr_data", c_swdata, q[0].d);
                chk("wr_addr", c_saddr, {q[0].a, 2'b00});
            end
        end
        if (p_done)              chk("bubble", active, 0);
        else if (p_active)       chk("req_held", {c_srready, active}, {p_read, 1'b1});
        else if (p_lpend)        chk("read_start", c_srready, 1);
        else if (p_qsize > 0)    chk("write_start", c_swvalid != 4'h0, 1);
        else                     chk("stay_idle", active, 0);

        @(posedge clk);
        p_active = active;
        p_done   = (c_srready && s_rvalid) || ((c_swvalid != 4'h0) && s_wready);
        p_read   = c_srready;
        p_lpend  = m_lpend;
        p_qsize  = q.size();
        m_rv     = 1'b0;
        if (r) begin
            q.delete();
            m_lpend = 1'b0; m_laddr = '0; m_rdata = '0;
            p_active = 1'b0; p_done = 1'b0; p_read = 1'b0; p_lpend = 1'b0; p_qsize = 0;
        end else begin
            if ((c_swvalid != 4'h0) && s_wready && (q.size() > 0)) void'(q.pop_front());
            if (v && exp_ready) begin
                if (wr) begin
                    if (s != 4'h0) q.push_back('{a[31:2], d, s});
                end else begin
                    m_lpend = 1'b1;
                    m_laddr = a;
                end
            end
            if (c_srready && s_rvalid) begin
                m_rdata = rd;
                m_lpend = 1'b0;
                m_rv    = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit rresp, input bit wresp, input logic [31:0] rd);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rresp, wresp, rd);
    endtask

    task automatic drain();
        int k = 0;
        do begin
            idle(1'b1, 1'b1, 32'hA5A5_0000 + 32'(k));
            k++;
        end while (!(c_empty && !c_srready && !m_lpend) && k < 100);
        chk("drain_done", c_empty, 1);
    endtask

    task automatic run_read(input logic [31:0] rd, output logic [31:0] saddr,
                            output int qs, output logic [31:0] rdata);
        bit seen = 1'b0;
        int k = 0;
        saddr = '1; qs = -1;
        do begin
            idle(1'b1, 1'b1, rd);
            if (c_srready && !seen) begin
                seen = 1'b1; saddr = c_saddr; qs = c_qsize;
            end
            k++;
        end while (!c_rvalid && k < 50);
        chk("read_done_in_time", c_rvalid, 1);
        rdata = c_rdata;
    endtask

    initial begin
        logic [31:0] sa, rdv, addr;
        int          qs;
        bit          rdy[5];
        int          k;

        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_wr = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        s_rdata = '0; s_rvalid = 1'b0; s_wready = 1'b0;
        q.delete(); m_lpend = 0; m_laddr = '0; m_rdata = '0; m_rv = 0;
        p_active = 0; p_done = 0; p_read = 0; p_lpend = 0; p_qsize = 0;

        // Reset values
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        idle(1'b0, 1'b0, 0);
        chk("rst_buf_empty", c_empty, 1);
        chk("rst_s_rready", c_srready, 0);
        chk("rst_s_wvalid", c_swvalid, 0);
        chk("rst_s_addr", c_saddr, 0);
        chk("rst_s_wdata", c_swdata, 0);
        chk("rst_cpu_rdata", c_rdata, 0);
        chk("rst_cpu_rvalid", c_rvalid, 0);

        // Single store, write issues two cycles later
        step(1'b0, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 0);
        chk("st_ready", c_ready, 1);
        idle(1'b0, 1'b0, 0);
        idle(1'b0, 1'b1, 0);
        chk("st_wvalid", c_swvalid, 4'hF);
        chk("st_saddr", c_saddr, 32'h1000);
        chk("st_wdata", c_swdata, 32'hDEADBEEF);
        idle(1'b0, 1'b0, 0);
        chk("st_empty_after", c_empty, 1);

        // Fill the FIFO; the fifth store waits for a real free slot
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'(i), 4'hF, 1'b0, 1'b0, 0);
            rdy[i] = c_ready;
        end
        chk("full_rdy0", rdy[0], 1);
        chk("full_rdy3", rdy[3], 1);
        chk("full_rdy4", rdy[4], 0);
        step(1'b0, 1'b1, 1'b1, 32'h110, 32'h5, 4'hF, 1'b0, 1'b1, 0);
        chk("full_pop_same_cycle", c_ready, 0);
        chk("full_head_wvalid", c_swvalid, 4'hF);
        step(1'b0, 1'b1, 1'b1, 32'h110, 32'h5, 4'hF, 1'b0, 1'b0, 0);
        chk("full_after_pop", c_ready, 1);
        drain();

        // Load to the same word as a buffered store stalls until it is written
        step(1'b0, 1'b1, 1'b1, 32'h2004, 32'h11, 4'hF, 1'b0, 1'b0, 0);
        k = 0;
        do begin
            step(1'b0, 1'b1, 1'b0, 32'h2006, 0, 0, 1'b0, k >= 2, 0);
            if (k == 0) chk("ld_conflict_stall", c_ready, 0);
            k++;
        end while (!c_ready && k < 20);
        chk("ld_accepted", c_ready, 1);
        run_read(32'hCAFE0001, sa, qs, rdv);
        chk("ld_saddr", sa, 32'h2006);
        chk("ld_rdata", rdv, 32'hCAFE0001);

        // Read bypasses the younger pending store
        step(1'b0, 1'b1, 1'b1, 32'h3000, 32'h30, 4'hF, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 32'h3004, 32'h34, 4'h3, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 32'h4000, 0, 0, 1'b0, 1'b0, 0);
        chk("byp_ld_ready", c_ready, 1);
        run_read(32'h12345678, sa, qs, rdv);
        chk("byp_saddr", sa, 32'h4000);
        chk("byp_store_still_queued", qs, 1);
        chk("byp_rdata", rdv, 32'h12345678);
        idle(1'b0, 1'b1, 0);
        chk("byp_rvalid_pulse", c_rvalid, 0);
        drain();

        // Zero-strobe store is accepted and dropped
        step(1'b0, 1'b1, 1'b1, 32'h5000, 32'h55, 4'h0, 1'b0, 1'b0, 0);
        chk("zs_ready", c_ready, 1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b1, 0);
            chk("zs_empty", c_empty, 1);
            chk("zs_no_write", c_swvalid, 0);
        end

        // Reset during an in-flight write with three entries queued
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 32'h6000 + 32'(4 * i), 32'h60 + 32'(i), 4'hF, 1'b0, 1'b0, 0);
        idle(1'b0, 1'b0, 0);
        chk("mid_wr_active", c_swvalid, 4'hF);
        chk("mid_wr_entries", c_qsize, 3);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        idle(1'b0, 1'b0, 0);
        chk("mid_rst_empty", c_empty, 1);
        chk("mid_rst_wvalid", c_swvalid, 0);

        // Randomized traffic over a small word pool to provoke conflicts
        for (int n = 0; n < 4000; n++) begin
            addr = 32'h8000 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
            step($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) == 1, addr, $urandom,
                 ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
